chain_race_trial: RTL and testbench

- Producer side of the delay-chain race calibration loop. Sequences repeated race trials between two programmable delay chains, "A" and "B".
- Applies the calibration tap settings it receives only at trial boundaries. Launches a common edge into both chains.
- Arbitrates which chain end arrives first and reports one result per trial on the a_wins/b_wins/valid interface.
- That interface is consumed by the calibration controller, which returns the calibrate_a/calibrate_b settings.

---
 rtl/chain_race_trial.sv | 164 ++++++++++++++++
 tb/tb_chain_race_trial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/chain_race_trial.sv
// Producer side of the delay-chain race calibration loop: loads chain taps at
// trial boundaries, launches a common edge and reports which chain end won.
module chain_race_trial #(
  parameter int CALIBRATE_BITS = 4,
  parameter int ARM_CYCLES     = 4,
  parameter int TIMEOUT        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CALIBRATE_BITS-1:0] calibrate_a,
  input  logic [CALIBRATE_BITS-1:0] calibrate_b,
  input  logic                      arrival_a,
  input  logic                      arrival_b,
  output logic [CALIBRATE_BITS-1:0] tap_a,
  output logic [CALIBRATE_BITS-1:0] tap_b,
  output logic                      launch,
  output logic                      a_wins,
  output logic                      b_wins,
  output logic                      valid,
  output logic                      stuck
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RACE,
    S_DECIDE,
    S_RELEASE
  } state_t;

  localparam logic [7:0] ARM_LAST     = 8'(ARM_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [CALIBRATE_BITS-1:0] tap_a_q, tap_a_d;
  logic [CALIBRATE_BITS-1:0] tap_b_q, tap_b_d;
  logic                      launch_q, launch_d;
  logic                      a_wins_q, a_wins_d;
  logic                      b_wins_q, b_wins_d;
  logic                      valid_q, valid_d;
  logic                      stuck_q, stuck_d;
  logic [1:0]                sync_a_q, sync_b_q;
  logic                      sa, sb;

  // Chain ends are asynchronous to clk; only the second flop's output is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      // NOTE: non-blocking so both flops sample the pre-edge value and form a real 2-stage chain.
      sync_a_q <= {sync_a_q[0], arrival_a};
      sync_b_q <= {sync_b_q[0], arrival_b};
    end
  end

  assign sa = sync_a_q[1];
  assign sb = sync_b_q[1];

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    tap_a_d  = tap_a_q;
    tap_b_d  = tap_b_q;
    launch_d = launch_q;
    valid_d  = 1'b0;
    a_wins_d = 1'b0;
    b_wins_d = 1'b0;
    stuck_d  = stuck_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          tap_a_d = calibrate_a;
          tap_b_d = calibrate_b;
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        // Leftover arrivals from a slow release would corrupt the race; wait them out.
        if (!(sa || sb)) begin
          if (cnt_q == ARM_LAST) begin
            launch_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_RACE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_RACE: begin
        if (sa || sb) begin
          a_wins_d = sa;
          b_wins_d = sb;
          valid_d  = 1'b1;
          state_d  = S_DECIDE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          valid_d = 1'b1;
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECIDE: begin
        launch_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_RELEASE;
      end

      S_RELEASE: begin
        if (!sa && !sb) begin
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          stuck_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tap_a_q  <= '0;
      tap_b_q  <= '0;
      launch_q <= 1'b0;
      a_wins_q <= 1'b0;
      b_wins_q <= 1'b0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tap_a_q  <= tap_a_d;
      tap_b_q  <= tap_b_d;
      launch_q <= launch_d;
      a_wins_q <= a_wins_d;
      b_wins_q <= b_wins_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign tap_a  = tap_a_q;
  assign tap_b  = tap_b_q;
  assign launch = launch_q;
  assign a_wins = a_wins_q;
  assign b_wins = b_wins_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_chain_race_trial.sv
// Directed bench for chain_race_trial: table of race trials plus hand-written
// stuck-release, reset-abort and back-to-back sequences.
module tb_chain_race_trial;

  localparam int NEVER = 1000;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] calibrate_a, calibrate_b;
  logic       arrival_a, arrival_b;
  logic [3:0] tap_a, tap_b;
  logic       launch, a_wins, b_wins, valid, stuck;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  chain_race_trial dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .calibrate_a(calibrate_a),
    .calibrate_b(calibrate_b),
    .arrival_a  (arrival_a),
    .arrival_b  (arrival_b),
    .tap_a      (tap_a),
    .tap_b      (tap_b),
    .launch     (launch),
    .a_wins     (a_wins),
    .b_wins     (b_wins),
    .valid      (valid),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_cnt <= valid_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] cal_a;
    logic [3:0] cal_b;
    logic [3:0] race_cal_a;  // value driven on calibrate_a once the race starts
    int         da;          // negedges after launch seen that arrival_a rises
    int         db;
    logic       exp_a;
    logic       exp_b;
    int         exp_k;       // negedge index after launch where valid is seen
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_trial(input vec_t v);
    int  k;
    bit  seen;
    calibrate_a = v.cal_a;
    calibrate_b = v.cal_b;
    enable      = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (launch) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("launch_rises", 32'(seen), 32'd1);
    if (!seen) return;
    check("tap_a_at_launch", 32'(tap_a), 32'(v.cal_a));
    check("tap_b_at_launch", 32'(tap_b), 32'(v.cal_b));
    calibrate_a = v.race_cal_a;
    k = 0;
    seen = 1'b0;
    while (k <= 40) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      if (k == 1) check("wins_low_without_valid", 32'({a_wins, b_wins}), 32'd0);
      if (k == v.da) arrival_a = 1'b1;
      if (k == v.db) arrival_b = 1'b1;
      @(negedge clk);
      k++;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("valid_latency", 32'(k), 32'(v.exp_k));
    check("a_wins", 32'(a_wins), 32'(v.exp_a));
    check("b_wins", 32'(b_wins), 32'(v.exp_b));
    check("launch_in_decide", 32'(launch), 32'd1);
    check("tap_a_held", 32'(tap_a), 32'(v.cal_a));
    @(negedge clk);
    check("valid_one_cycle", 32'(valid), 32'd0);
    check("launch_falls", 32'(launch), 32'd0);
    arrival_a = 1'b0;
    arrival_b = 1'b0;
  endtask

  initial begin
    int   n;
    int   start_cnt;
    bit   ok;
    vec_t v;

    vecs[0] = '{4'h3, 4'h5, 4'h3, 3,     10,    1'b1, 1'b0, 6};
    vecs[1] = '{4'h9, 4'h2, 4'h9, 5,     5,     1'b1, 1'b1, 8};
    vecs[2] = '{4'hA, 4'h1, 4'hA, NEVER, 0,     1'b0, 1'b1, 3};
    vecs[3] = '{4'hF, 4'h0, 4'hF, NEVER, NEVER, 1'b0, 1'b0, 32};
    vecs[4] = '{4'h0, 4'hF, 4'h0, 29,    NEVER, 1'b1, 1'b0, 32};
    vecs[5] = '{4'h7, 4'h7, 4'h7, 30,    30,    1'b0, 1'b0, 32};
    vecs[6] = '{4'h1, 4'hE, 4'h1, 12,    11,    1'b0, 1'b1, 14};
    vecs[7] = '{4'h0, 4'h4, 4'h9, 2,     NEVER, 1'b1, 1'b0, 5};
    vecs[8] = '{4'h9, 4'h4, 4'h9, NEVER, 4,     1'b0, 1'b1, 7};

    rst_n = 1'b0;
    enable = 1'b0;
    calibrate_a = '0;
    calibrate_b = '0;
    arrival_a = 1'b0;
    arrival_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({tap_a, tap_b, launch, a_wins, b_wins, valid, stuck}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_trial(vecs[i]);
      check("stuck_clear", 32'(stuck), 32'd0);
    end

    // 256 back-to-back trials, each won by chain A immediately.
    start_cnt = valid_cnt;
    v = '{4'h2, 4'h3, 4'h2, 0, NEVER, 1'b1, 1'b0, 3};
    for (int t = 0; t < 256; t++) run_trial(v);
    @(negedge clk);
    check("valid_pulse_count", 32'(valid_cnt - start_cnt), 32'd256);

    // Chain B never releases: stuck after TIMEOUT cycles in RELEASE, then ARM waits.
    v = '{4'h4, 4'h6, 4'h4, NEVER, 0, 1'b0, 1'b1, 3};
    calibrate_a = v.cal_a;
    calibrate_b = v.cal_b;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (launch) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stuck_launch", 32'(ok), 32'd1);
    arrival_b = 1'b1;
    repeat (3) @(negedge clk);
    check("stuck_trial_valid", 32'({valid, a_wins, b_wins}), 32'b101);
    repeat (32) @(negedge clk);
    check("stuck_before_timeout", 32'(stuck), 32'd0);
    @(negedge clk);
    check("stuck_at_timeout", 32'(stuck), 32'd1);
    ok = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (launch) ok = 1'b1;
    end
    check("no_launch_while_stale", 32'(ok), 32'd0);
    arrival_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (launch) begin
        ok = 1'b1;
        break;
      end
    end
    check("launch_after_release", 32'(ok), 32'd1);
    enable = 1'b0;
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("disabled_trial_completes", 32'({valid, a_wins, b_wins}), 32'b100);
    check("stuck_sticky", 32'(stuck), 32'd1);
    repeat (10) @(negedge clk);
    check("idle_when_disabled", 32'({launch, valid}), 32'd0);

    // Reset mid-RACE aborts the trial and clears stuck.
    calibrate_a = 4'h6;
    calibrate_b = 4'h8;
    enable = 1'b1;
    n = 0;
    while (!launch && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("race_before_reset", 32'(launch), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort", 32'({launch, valid, stuck, tap_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!launch && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("relaunch_latency", 32'(n), 32'd5);
    run_trial('{4'h6, 4'h8, 4'h6, 1, NEVER, 1'b1, 1'b0, 4});
    check("stuck_after_reset", 32'(stuck), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
